pipeline_exe: RTL

// Execute stage of the RV32IM pipeline. Sits directly downstream of the ID/EX register.
// - Performs ALU ops, address generation, branch resolution and RV32M mul/div.
// - Registers the results into the EX/MEM boundary.
// - Single-cycle for all ops except DIV/DIVU/REM/REMU.
// - DIV/DIVU/REM/REMU use a radix-2 iterative divider. stall_out holds the ID/EX register
//   (wired to its nop_output) while the divider is busy.

---
 rtl/pipeline_exe.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_exe.sv
// Execute stage of the RV32IM pipeline: single-cycle ALU, branch, address and multiply,
// plus a radix-2 restoring divider that holds ID/EX while it iterates.
module pipeline_exe #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode_in,
    input  logic [4:0]      rd_in,
    input  logic [2:0]      funct3_in,
    input  logic [6:0]      funct7_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            stall_out,
    output logic            out_valid,
    output logic [6:0]      opcode_out,
    output logic [4:0]      rd_out,
    output logic [2:0]      funct3_out,
    output logic [XLEN-1:0] result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic            br_taken_out,
    output logic [XLEN-1:0] br_target_out
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] FUNCT7_M   = 7'b0000001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_next;
    logic [4:0]      count;
    logic            div_neg_a, div_neg_b, div_zero, div_is_rem;
    logic [XLEN-1:0] quot_r, rem_r, divisor_r;
    logic [4:0]      sv_rd;
    logic [2:0]      sv_funct3;
    logic [6:0]      sv_opcode;

    logic [XLEN-1:0] op_b, alu_res, sra_res, mul_res;
    logic [XLEN-1:0] ex_result, ex_target, div_result;
    logic            ex_valid, ex_taken, is_m, is_div, br_cond, div_signed;
    logic            mul_a_signed, mul_b_signed;
    logic [63:0]     mul_a, mul_b, mul_prod;
    logic [XLEN:0]   div_shift, div_trial;
    logic [XLEN-1:0] q_fixed, r_mag, r_fixed;

    // Combinational execute for everything that completes in one cycle.
    always_comb begin
        op_b         = (opcode_in == OPC_OP) ? rs2_data_in : imm_in;
        sra_res      = $signed(rs1_data_in) >>> op_b[4:0];
        is_m         = ENABLE_M && (opcode_in == OPC_OP) && (funct7_in == FUNCT7_M);
        is_div       = is_m && funct3_in[2];
        div_signed   = !funct3_in[0];
        mul_a_signed = (funct3_in[1:0] == 2'b01) || (funct3_in[1:0] == 2'b10);
        mul_b_signed = (funct3_in[1:0] == 2'b01);
        mul_a        = {{32{mul_a_signed & rs1_data_in[31]}}, rs1_data_in};
        mul_b        = {{32{mul_b_signed & rs2_data_in[31]}}, rs2_data_in};
        mul_prod     = mul_a * mul_b;
        mul_res      = (funct3_in[1:0] == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];

        case (funct3_in)
            3'b000: alu_res = (opcode_in == OPC_OP && funct7_in[5]) ? rs1_data_in - op_b
                                                                    : rs1_data_in + op_b;
            3'b001: alu_res = rs1_data_in << op_b[4:0];
            3'b010: alu_res = {31'b0, $signed(rs1_data_in) < $signed(op_b)};
            3'b011: alu_res = {31'b0, rs1_data_in < op_b};
            3'b100: alu_res = rs1_data_in ^ op_b;
            3'b101: alu_res = funct7_in[5] ? sra_res : rs1_data_in >> op_b[4:0];
            3'b110: alu_res = rs1_data_in | op_b;
            default: alu_res = rs1_data_in & op_b;
        endcase

        case (funct3_in)
            3'b000:  br_cond = (rs1_data_in == rs2_data_in);
            3'b001:  br_cond = (rs1_data_in != rs2_data_in);
            3'b100:  br_cond = ($signed(rs1_data_in) < $signed(rs2_data_in));
            3'b101:  br_cond = ($signed(rs1_data_in) >= $signed(rs2_data_in));
            3'b110:  br_cond = (rs1_data_in < rs2_data_in);
            3'b111:  br_cond = (rs1_data_in >= rs2_data_in);
            default: br_cond = 1'b0;
        endcase

        ex_valid  = 1'b1;
        ex_result = '0;
        ex_taken  = 1'b0;
        ex_target = '0;
        case (opcode_in)
            OPC_OP: begin
                ex_valid  = ENABLE_M || (funct7_in != FUNCT7_M);
                ex_result = is_m ? mul_res : alu_res;
            end
            OPC_OP_IMM: ex_result = alu_res;
            OPC_LUI:    ex_result = imm_in;
            OPC_AUIPC:  ex_result = pc_in + imm_in;
            OPC_JAL: begin
                ex_result = pc_in + 32'd4;
                ex_taken  = 1'b1;
                ex_target = pc_in + imm_in;
            end
            OPC_JALR: begin
                ex_result = pc_in + 32'd4;
                ex_taken  = 1'b1;
                ex_target = (rs1_data_in + imm_in) & ~32'd1;
            end
            OPC_BRANCH: begin
                ex_taken  = br_cond;
                ex_target = pc_in + imm_in;
            end
            OPC_LOAD, OPC_STORE: ex_result = rs1_data_in + imm_in;
            default: ex_valid = 1'b0;
        endcase
    end

    // Divider datapath: one restoring step, and the final sign correction.
    always_comb begin
        div_shift  = {rem_r, quot_r[XLEN-1]};
        div_trial  = div_shift - {1'b0, divisor_r};
        r_mag      = div_zero ? quot_r : rem_r;
        r_fixed    = div_neg_a ? -r_mag : r_mag;
        q_fixed    = div_zero ? '1 : ((div_neg_a ^ div_neg_b) ? -quot_r : quot_r);
        div_result = div_is_rem ? r_fixed : q_fixed;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (is_div) state_next = BUSY;
            BUSY:    if (count == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall_out = (state == BUSY);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Divide-by-zero skips iteration so quot_r still holds |dividend| for the remainder.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count          <= '0;
            div_neg_a      <= 1'b0;
            div_neg_b      <= 1'b0;
            div_zero       <= 1'b0;
            div_is_rem     <= 1'b0;
            quot_r         <= '0;
            rem_r          <= '0;
            divisor_r      <= '0;
            sv_rd          <= '0;
            sv_funct3      <= '0;
            sv_opcode      <= '0;
            out_valid      <= 1'b0;
            opcode_out     <= '0;
            rd_out         <= '0;
            funct3_out     <= '0;
            result_out     <= '0;
            store_data_out <= '0;
            br_taken_out   <= 1'b0;
            br_target_out  <= '0;
        end else begin
            count <= (state == BUSY) ? count + 5'd1 : 5'd0;
            case (state)
                IDLE: begin
                    if (is_div) begin
                        div_neg_a  <= div_signed & rs1_data_in[31];
                        div_neg_b  <= div_signed & rs2_data_in[31];
                        div_zero   <= (rs2_data_in == '0);
                        div_is_rem <= funct3_in[1];
                        quot_r     <= (div_signed & rs1_data_in[31]) ? -rs1_data_in : rs1_data_in;
                        divisor_r  <= (div_signed & rs2_data_in[31]) ? -rs2_data_in : rs2_data_in;
                        rem_r      <= '0;
                        sv_rd      <= rd_in;
                        sv_funct3  <= funct3_in;
                        sv_opcode  <= opcode_in;
                        out_valid  <= 1'b0;
                    end else begin
                        out_valid      <= ex_valid;
                        opcode_out     <= opcode_in;
                        rd_out         <= rd_in;
                        funct3_out     <= funct3_in;
                        result_out     <= ex_result;
                        store_data_out <= rs2_data_in;
                        br_taken_out   <= ex_taken;
                        br_target_out  <= ex_target;
                    end
                end
                BUSY: begin
                    if (!div_zero) begin
                        if (!div_trial[XLEN]) begin
                            rem_r  <= div_trial[XLEN-1:0];
                            quot_r <= {quot_r[XLEN-2:0], 1'b1};
                        end else begin
                            rem_r  <= div_shift[XLEN-1:0];
                            quot_r <= {quot_r[XLEN-2:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    out_valid      <= 1'b1;
                    opcode_out     <= sv_opcode;
                    rd_out         <= sv_rd;
                    funct3_out     <= sv_funct3;
                    result_out     <= div_result;
                    store_data_out <= '0;
                    br_taken_out   <= 1'b0;
                    br_target_out  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
